wb_write_queue: RTL and testbench

- Writer-side front end for the 32-entry, 2-read/1-write register file.
- Accepts write-back results (rd, data) from execute/load units, buffers them in a small in-order FIFO, and drains one entry per cycle into the register file write port (we/rd_addr/rd_data).
- Provides a two-port bypass lookup so decode reads see pending writes that have not yet reached the register file.
- Write-back producers never stall on the register file, except when the queue is full.

---
 rtl/wb_write_queue_if.sv | 41 ++++
 rtl/wb_write_queue.sv | 100 ++++++++++
 tb/tb_wb_write_queue.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_write_queue_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_write_queue_if : producer, register-file drain and bypass signals
// Revision: 1.0
// ---------------------------------------------------------------------------
interface wb_write_queue_if #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int AW    = 5
);
  localparam int c_cnt_w = $clog2(DEPTH) + 1;

  logic               in_valid;
  logic               in_ready;
  logic [AW-1:0]      in_rd;
  logic [XLEN-1:0]    in_data;
  logic               rf_stall;
  logic               rf_we;
  logic [AW-1:0]      rf_rd_addr;
  logic [XLEN-1:0]    rf_rd_data;
  logic [AW-1:0]      q_rs1_addr;
  logic               q_rs1_hit;
  logic [XLEN-1:0]    q_rs1_data;
  logic [AW-1:0]      q_rs2_addr;
  logic               q_rs2_hit;
  logic [XLEN-1:0]    q_rs2_data;
  logic [c_cnt_w-1:0] count;

  modport master (
    output in_valid, in_rd, in_data, rf_stall, q_rs1_addr, q_rs2_addr,
    input  in_ready, rf_we, rf_rd_addr, rf_rd_data,
           q_rs1_hit, q_rs1_data, q_rs2_hit, q_rs2_data, count
  );

  modport slave (
    input  in_valid, in_rd, in_data, rf_stall, q_rs1_addr, q_rs2_addr,
    output in_ready, rf_we, rf_rd_addr, rf_rd_data,
           q_rs1_hit, q_rs1_data, q_rs2_hit, q_rs2_data, count
  );
endinterface
`default_nettype wire

// File: rtl/wb_write_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_write_queue : in-order write-back FIFO draining into the register file,
//                  with a two-port youngest-match bypass lookup
// Revision: 1.0
// ---------------------------------------------------------------------------
module wb_write_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int AW    = 5
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  wb_write_queue_if.slave   bus
);
  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0]   r_valid;
  logic [AW-1:0]      r_rd   [DEPTH];
  logic [XLEN-1:0]    r_data [DEPTH];
  logic [c_ptr_w-1:0] r_wptr;
  logic [c_ptr_w-1:0] r_rptr;
  logic [c_cnt_w-1:0] r_count;

  logic w_empty;
  logic w_ready;
  logic w_we;
  logic w_push;

  assign w_empty = (r_count == '0);
  assign w_ready = (r_count < c_cnt_w'(DEPTH));
  assign w_we    = !w_empty && !bus.rf_stall;
  // x0 results complete the handshake but are never stored.
  assign w_push  = bus.in_valid && w_ready && (bus.in_rd != '0);

  assign bus.in_ready   = w_ready;
  assign bus.rf_we      = w_we;
  assign bus.rf_rd_addr = w_empty ? '0 : r_rd[r_rptr];
  assign bus.rf_rd_data = w_empty ? '0 : r_data[r_rptr];
  assign bus.count      = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i]   <= '0;
        r_data[i] <= '0;
      end
    end else begin
      // Push and pop never target the same slot: a full queue refuses pushes.
      if (w_push) begin
        r_valid[r_wptr] <= 1'b1;
        r_rd[r_wptr]    <= bus.in_rd;
        r_data[r_wptr]  <= bus.in_data;
        r_wptr          <= r_wptr + 1'b1;
      end
      if (w_we) begin
        r_valid[r_rptr] <= 1'b0;
        r_rptr          <= r_rptr + 1'b1;
      end
      case ({w_push, w_we})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_lookup
    logic [AW-1:0]   w_addr;
    logic            w_hit;
    logic [XLEN-1:0] w_data;

    assign w_addr = (p == 0) ? bus.q_rs1_addr : bus.q_rs2_addr;

    // Scan oldest to youngest so the last match, the youngest, wins.
    always_comb begin
      w_hit  = 1'b0;
      w_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if ((w_addr != '0) && r_valid[r_rptr + c_ptr_w'(i)] &&
            (r_rd[r_rptr + c_ptr_w'(i)] == w_addr)) begin
          w_hit  = 1'b1;
          w_data = r_data[r_rptr + c_ptr_w'(i)];
        end
      end
    end
  end

  assign bus.q_rs1_hit  = g_lookup[0].w_hit;
  assign bus.q_rs1_data = g_lookup[0].w_data;
  assign bus.q_rs2_hit  = g_lookup[1].w_hit;
  assign bus.q_rs2_data = g_lookup[1].w_data;

endmodule
`default_nettype wire

// File: tb/tb_wb_write_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_wb_write_queue : directed scenarios plus randomized traffic against a
//                     queue-based reference model of wb_write_queue
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_wb_write_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int c_cnt_w = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_write_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) bus ();

  wb_write_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int we_in_reset = 0;

  ent_t            mq[$];
  logic [XLEN-1:0] rfm    [32];
  logic [XLEN-1:0] dut_rf [32];

  // Register file written by the DUT's drain port.
  always @(posedge clk) begin
    if (!rst_n && bus.rf_we) we_in_reset++;
    if (rst_n && bus.rf_we) dut_rf[bus.rf_rd_addr] <= bus.rf_rd_data;
  end

  function automatic logic [XLEN:0] m_lookup(input logic [AW-1:0] addr);
    if (addr == '0) return '0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].rd == addr) return {1'b1, mq[i].data};
    return '0;
  endfunction

  function automatic logic [AW+XLEN:0] m_head(input logic stall);
    if (mq.size() == 0) return '0;
    return {!stall, mq[0].rd, mq[0].data};
  endfunction

  // Advance one clock, updating the model from the inputs held across the edge.
  task automatic tick();
    bit   push, pop;
    ent_t h;
    push = bus.in_valid && (mq.size() < DEPTH) && (bus.in_rd != '0);
    pop  = (mq.size() != 0) && !bus.rf_stall;
    h    = '{rd: bus.in_rd, data: bus.in_data};
    @(posedge clk);
    if (pop) begin
      ent_t o;
      o = mq.pop_front();
      rfm[o.rd] = o.data;
    end
    if (push) mq.push_back(h);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] rd,
                       input logic [XLEN-1:0] d, input logic stall);
    bus.in_valid = v;
    bus.in_rd    = rd;
    bus.in_data  = d;
    bus.rf_stall = stall;
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, '0, '0, 1'b0);
    bus.q_rs1_addr = 5'd1;
    bus.q_rs2_addr = 5'd2;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({bus.rf_we, bus.in_ready, bus.count, bus.rf_rd_addr, bus.rf_rd_data} !==
        {1'b0, 1'b1, c_cnt_w'(0), AW'(0), XLEN'(0)}) begin
      n_err++;
      $display("FAIL reset_held: we/ready/count/addr/data=%0b/%0b/%0d/%0d/%0d want 0/1/0/0/0",
               bus.rf_we, bus.in_ready, bus.count, bus.rf_rd_addr, bus.rf_rd_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      tick();
      n_vec++;
      if ({bus.rf_we, bus.in_ready, bus.count, bus.q_rs1_hit, bus.q_rs1_data} !==
          {1'b0, 1'b1, c_cnt_w'(0), 1'b0, XLEN'(0)}) begin
        n_err++;
        $display("FAIL reset_idle: we/ready/count/hit=%0b/%0b/%0d/%0b want 0/1/0/0",
                 bus.rf_we, bus.in_ready, bus.count, bus.q_rs1_hit);
      end
    end
  endtask

  task automatic test_single_write();
    drive(1'b1, 5'd1, 32'd42, 1'b0);
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL single_ready: got %0b want 1", bus.in_ready);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0);
    n_vec++;
    if ({bus.rf_we, bus.rf_rd_addr, bus.rf_rd_data, bus.count} !==
        {1'b1, AW'(1), XLEN'(42), c_cnt_w'(1)}) begin
      n_err++;
      $display("FAIL single_present: we/addr/data/count=%0b/%0d/%0d/%0d want 1/1/42/1",
               bus.rf_we, bus.rf_rd_addr, bus.rf_rd_data, bus.count);
    end
    tick();
    n_vec++;
    if ({bus.count, bus.rf_we, dut_rf[1]} !== {c_cnt_w'(0), 1'b0, XLEN'(42)}) begin
      n_err++;
      $display("FAIL single_written: count/we/x1=%0d/%0b/%0d want 0/0/42",
               bus.count, bus.rf_we, dut_rf[1]);
    end
  endtask

  task automatic test_fill_stall();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, AW'(2 + k), XLEN'(7 + k), 1'b1);
      tick();
    end
    drive(1'b1, 5'd6, 32'd99, 1'b1);
    n_vec++;
    if ({bus.count, bus.in_ready, bus.rf_we} !== {c_cnt_w'(4), 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL fill_full: count/ready/we=%0d/%0b/%0b want 4/0/0",
               bus.count, bus.in_ready, bus.rf_we);
    end
    tick();
    drive(1'b0, '0, '0, 1'b1);
    n_vec++;
    if (bus.count !== c_cnt_w'(4)) begin
      n_err++; $display("FAIL fill_refused: count=%0d want 4", bus.count);
    end
    drive(1'b0, '0, '0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if ({bus.rf_we, bus.rf_rd_addr, bus.rf_rd_data} !== {1'b1, AW'(2 + k), XLEN'(7 + k)}) begin
        n_err++;
        $display("FAIL fill_drain%0d: we/addr/data=%0b/%0d/%0d want 1/%0d/%0d",
                 k, bus.rf_we, bus.rf_rd_addr, bus.rf_rd_data, 2 + k, 7 + k);
      end
      tick();
    end
    n_vec++;
    if ({bus.count, bus.rf_we} !== {c_cnt_w'(0), 1'b0}) begin
      n_err++; $display("FAIL fill_empty: count/we=%0d/%0b want 0/0", bus.count, bus.rf_we);
    end
  endtask

  task automatic test_bypass_youngest();
    drive(1'b1, 5'd3, 32'd11, 1'b1);
    tick();
    drive(1'b1, 5'd3, 32'd22, 1'b1);
    tick();
    bus.q_rs1_addr = 5'd3;
    drive(1'b0, '0, '0, 1'b1);
    n_vec++;
    if ({bus.q_rs1_hit, bus.q_rs1_data} !== {1'b1, XLEN'(22)}) begin
      n_err++;
      $display("FAIL bypass_young: hit/data=%0b/%0d want 1/22", bus.q_rs1_hit, bus.q_rs1_data);
    end
    drive(1'b0, '0, '0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if ({bus.q_rs1_hit, bus.q_rs1_data} !== ((k < 2) ? {1'b1, XLEN'(22)} : {1'b0, XLEN'(0)})) begin
        n_err++;
        $display("FAIL bypass_drain%0d: hit/data=%0b/%0d want %0d/%0d",
                 k, bus.q_rs1_hit, bus.q_rs1_data, (k < 2), (k < 2) ? 22 : 0);
      end
      tick();
    end
    n_vec++;
    if (dut_rf[3] !== 32'd22) begin
      n_err++; $display("FAIL bypass_order: x3=%0d want 22", dut_rf[3]);
    end
  endtask

  task automatic test_x0();
    bus.q_rs2_addr = 5'd0;
    drive(1'b1, 5'd0, 32'd999, 1'b0);
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_err++; $display("FAIL x0_ready: got %0b want 1", bus.in_ready);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0);
    n_vec++;
    if ({bus.count, bus.rf_we, bus.q_rs2_hit, bus.q_rs2_data} !==
        {c_cnt_w'(0), 1'b0, 1'b0, XLEN'(0)}) begin
      n_err++;
      $display("FAIL x0_ignored: count/we/hit/data=%0d/%0b/%0b/%0d want 0/0/0/0",
               bus.count, bus.rf_we, bus.q_rs2_hit, bus.q_rs2_data);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, AW'(7 + k), XLEN'(100 + k), 1'b1);
      tick();
    end
    drive(1'b0, '0, '0, 1'b1);
    bus.q_rs1_addr = 5'd7;
    n_vec++;
    if (bus.count !== c_cnt_w'(3)) begin
      n_err++; $display("FAIL mid_pending: count=%0d want 3", bus.count);
    end
    we_in_reset = 0;
    #2 rst_n = 1'b0;
    #1;
    mq.delete();
    bus.rf_stall = 1'b0;
    #1;
    n_vec++;
    if ({bus.count, bus.in_ready, bus.rf_we, bus.q_rs1_hit} !== {c_cnt_w'(0), 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL mid_reset: count/ready/we/hit=%0d/%0b/%0b/%0b want 0/1/0/0",
               bus.count, bus.in_ready, bus.rf_we, bus.q_rs1_hit);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_vec++;
    if ({we_in_reset, bus.rf_we, bus.count, dut_rf[7]} !== {32'd0, 1'b0, c_cnt_w'(0), XLEN'(0)}) begin
      n_err++;
      $display("FAIL mid_dropped: we_pulses/we/count/x7=%0d/%0b/%0d/%0d want 0/0/0/0",
               we_in_reset, bus.rf_we, bus.count, dut_rf[7]);
    end
  endtask

  task automatic test_random();
    logic [XLEN:0]      l1, l2;
    logic [AW+XLEN:0]   hd;
    logic [c_cnt_w-1:0] ecnt;
    int                 bad;
    for (int c = 0; c < 600; c++) begin
      drive(($urandom_range(0, 9) < 6), AW'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 9) < 4));
      bus.q_rs1_addr = AW'($urandom_range(0, 7));
      bus.q_rs2_addr = AW'($urandom_range(0, 7));
      #1;
      l1   = m_lookup(bus.q_rs1_addr);
      l2   = m_lookup(bus.q_rs2_addr);
      hd   = m_head(bus.rf_stall);
      ecnt = c_cnt_w'(mq.size());
      n_vec++;
      if ({bus.in_ready, bus.count} !== {(mq.size() < DEPTH), ecnt}) begin
        n_err++;
        $display("FAIL rnd_count c%0d: ready/count=%0b/%0d want %0b/%0d",
                 c, bus.in_ready, bus.count, (mq.size() < DEPTH), ecnt);
      end
      n_vec++;
      if ({bus.rf_we, bus.rf_rd_addr, bus.rf_rd_data} !== hd) begin
        n_err++;
        $display("FAIL rnd_drain c%0d: we/addr/data=%0b/%0d/%h want %0b/%0d/%h", c,
                 bus.rf_we, bus.rf_rd_addr, bus.rf_rd_data, hd[AW+XLEN], hd[AW+XLEN-1:XLEN], hd[XLEN-1:0]);
      end
      n_vec++;
      if ({bus.q_rs1_hit, bus.q_rs1_data, bus.q_rs2_hit, bus.q_rs2_data} !== {l1, l2}) begin
        n_err++;
        $display("FAIL rnd_bypass c%0d: p1 %0b/%h p2 %0b/%h want %0b/%h %0b/%h", c,
                 bus.q_rs1_hit, bus.q_rs1_data, bus.q_rs2_hit, bus.q_rs2_data,
                 l1[XLEN], l1[XLEN-1:0], l2[XLEN], l2[XLEN-1:0]);
      end
      tick();
    end
    drive(1'b0, '0, '0, 1'b0);
    repeat (DEPTH + 1) tick();
    bad = 0;
    for (int r = 1; r < 32; r++) if (dut_rf[r] !== rfm[r]) bad++;
    n_vec++;
    if (bad != 0 || bus.count !== c_cnt_w'(0)) begin
      n_err++;
      $display("FAIL rnd_regfile: %0d registers differ, count=%0d want 0 and 0", bad, bus.count);
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin
      rfm[r]    = '0;
      dut_rf[r] = '0;
    end
    bus.in_valid   = 1'b0;
    bus.in_rd      = '0;
    bus.in_data    = '0;
    bus.rf_stall   = 1'b0;
    bus.q_rs1_addr = '0;
    bus.q_rs2_addr = '0;
    test_reset();
    test_single_write();
    test_fill_stall();
    test_bypass_youngest();
    test_x0();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, want completion");
    $fatal(1);
  end
endmodule
`default_nettype wire
